motion_arbiter: RTL

Frame-rate controller that decides the ball's per-frame motion vector. It arbitrates between the keyboard (keycode) and an autopilot requester, and applies wall bounces. It predicts the next position so that a reflection takes effect in the same frame, then holds off both requesters briefly. Its outputs drive the ball position datapath, which only accumulates `Motion_X/Motion_Y` into its position registers.

---
 rtl/motion_pkg.sv | 61 ++++++
 rtl/wall_predict.sv | 68 ++++++
 rtl/motion_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared types, key codes and motion helpers for motion_arbiter
package motion_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_LEFT  = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_UP    = 3'd3,
    DIR_DOWN  = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEY     = 2'd1,
    AUTO    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_W = 8'h1A;

  localparam int MOTION_W = 10;

  typedef struct packed {
    logic [MOTION_W-1:0] x;
    logic [MOTION_W-1:0] y;
  } motion_t;

  // Screen coordinates: +Y points down, so UP is a negative Y step.
  function automatic motion_t dir_to_motion(input dir_t dir, input logic [MOTION_W-1:0] step);
    motion_t m;
    m = '0;
    case (dir)
      DIR_LEFT:  m.x = -step;
      DIR_RIGHT: m.x = step;
      DIR_UP:    m.y = -step;
      DIR_DOWN:  m.y = step;
      default:   m = '0;
    endcase
    return m;
  endfunction

  function automatic logic is_dir_key(input logic [7:0] code);
    return (code == KEY_A) || (code == KEY_D) || (code == KEY_S) || (code == KEY_W);
  endfunction

  function automatic dir_t key_to_dir(input logic [7:0] code);
    dir_t d;
    case (code)
      KEY_A:   d = DIR_LEFT;
      KEY_D:   d = DIR_RIGHT;
      KEY_S:   d = DIR_DOWN;
      KEY_W:   d = DIR_UP;
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wall_predict.sv
// rtl/wall_predict.sv - combinational wall-bounce prediction on ball position plus next motion
module wall_predict
  import motion_pkg::*;
#(
  parameter int unsigned X_MIN = 0,
  parameter int unsigned X_MAX = 639,
  parameter int unsigned Y_MIN = 0,
  parameter int unsigned Y_MAX = 479,
  parameter int unsigned STEP  = 1
) (
  input  logic [MOTION_W-1:0] ball_x,
  input  logic [MOTION_W-1:0] ball_y,
  input  logic [MOTION_W-1:0] ball_s,
  input  logic [MOTION_W-1:0] motion_x,
  input  logic [MOTION_W-1:0] motion_y,
  output logic                bounce,
  output logic [MOTION_W-1:0] refl_x,
  output logic [MOTION_W-1:0] refl_y
);

  localparam logic [MOTION_W:0]   X_MIN_W = (MOTION_W+1)'(X_MIN);
  localparam logic [MOTION_W:0]   X_MAX_W = (MOTION_W+1)'(X_MAX);
  localparam logic [MOTION_W:0]   Y_MIN_W = (MOTION_W+1)'(Y_MIN);
  localparam logic [MOTION_W:0]   Y_MAX_W = (MOTION_W+1)'(Y_MAX);
  localparam logic [MOTION_W:0]   STEP_W  = (MOTION_W+1)'(STEP);
  localparam logic [MOTION_W-1:0] STEP_M  = MOTION_W'(STEP);

  logic [MOTION_W:0] far_x, near_x, far_y, near_y;
  logic [MOTION_W:0] pos_x, pos_y;
  logic              inc_x, dec_x, inc_y, dec_y;

  // Edges are compared in additive form so a small ball near zero never wraps.
  always_comb begin
    pos_x  = {1'b0, ball_x};
    pos_y  = {1'b0, ball_y};
    far_x  = pos_x + {1'b0, ball_s} + STEP_W;
    far_y  = pos_y + {1'b0, ball_s} + STEP_W;
    near_x = X_MIN_W + {1'b0, ball_s} + STEP_W;
    near_y = Y_MIN_W + {1'b0, ball_s} + STEP_W;

    inc_x = (motion_x != '0) && !motion_x[MOTION_W-1];
    dec_x = motion_x[MOTION_W-1];
    inc_y = (motion_y != '0) && !motion_y[MOTION_W-1];
    dec_y = motion_y[MOTION_W-1];

    bounce = 1'b0;
    refl_x = motion_x;
    refl_y = motion_y;
    if (inc_y && (far_y >= Y_MAX_W)) begin
      bounce = 1'b1;
      refl_x = '0;
      refl_y = -STEP_M;
    end else if (dec_y && (pos_y <= near_y)) begin
      bounce = 1'b1;
      refl_x = '0;
      refl_y = STEP_M;
    end else if (inc_x && (far_x >= X_MAX_W)) begin
      bounce = 1'b1;
      refl_x = -STEP_M;
      refl_y = '0;
    end else if (dec_x && (pos_x <= near_x)) begin
      bounce = 1'b1;
      refl_x = STEP_M;
      refl_y = '0;
    end
  end

endmodule

// File: rtl/motion_arbiter.sv
// rtl/motion_arbiter.sv - per-frame arbitration of ball motion between keyboard, autopilot and walls
module motion_arbiter
  import motion_pkg::*;
#(
  parameter int unsigned X_MIN          = 0,
  parameter int unsigned X_MAX          = 639,
  parameter int unsigned Y_MIN          = 0,
  parameter int unsigned Y_MAX          = 479,
  parameter int unsigned STEP           = 1,
  parameter int unsigned IDLE_FRAMES    = 60,
  parameter int unsigned HOLDOFF_FRAMES = 8
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic [7:0]          keycode,
  input  logic                auto_req,
  input  dir_t                auto_dir,
  input  logic [MOTION_W-1:0] BallX,
  input  logic [MOTION_W-1:0] BallY,
  input  logic [MOTION_W-1:0] BallS,
  output logic [MOTION_W-1:0] Motion_X,
  output logic [MOTION_W-1:0] Motion_Y,
  output logic                Owner,
  output logic                auto_ack,
  output logic                Bounce
);

  localparam int IW = (IDLE_FRAMES > 0) ? $clog2(IDLE_FRAMES + 1) : 1;
  localparam int HW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
  localparam logic [IW-1:0]       IDLE_MAX = IW'(IDLE_FRAMES);
  localparam logic [HW-1:0]       HOLD_MAX = HW'(HOLDOFF_FRAMES);
  localparam logic [MOTION_W-1:0] STEP_M   = MOTION_W'(STEP);

  state_t        state_q, state_d, nom_state;
  state_t        ret_q, ret_d;
  motion_t       motion_q, motion_d, cand;
  logic          owner_q, owner_d;
  logic          ack_q, ack_d;
  logic          bounce_q, bounce_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_nom;

  logic          key_hit, idle_full, wall_hit;
  motion_t       key_mot, auto_mot;
  logic [MOTION_W-1:0] refl_x, refl_y;

  // Requester arbitration: the candidate motion before walls are considered.
  always_comb begin
    key_hit   = is_dir_key(keycode);
    key_mot   = dir_to_motion(key_to_dir(keycode), STEP_M);
    auto_mot  = dir_to_motion(auto_dir, STEP_M);
    idle_full = (idle_cnt_q == IDLE_MAX);

    idle_cnt_d = idle_cnt_q;
    if (key_hit) begin
      idle_cnt_d = '0;
    end else if (!idle_full) begin
      idle_cnt_d = idle_cnt_q + IW'(1);
    end

    nom_state = state_q;
    cand      = motion_q;
    ack_d     = 1'b0;
    hold_nom  = hold_cnt_q;
    case (state_q)
      IDLE: begin
        cand = '0;
        if (key_hit) begin
          nom_state = KEY;
          cand      = key_mot;
        end else if (auto_req && idle_full) begin
          nom_state = AUTO;
          cand      = auto_mot;
          ack_d     = 1'b1;
        end
      end
      KEY: begin
        if (key_hit) begin
          cand = key_mot;
        end else if (auto_req && idle_full) begin
          nom_state = AUTO;
          cand      = auto_mot;
          ack_d     = 1'b1;
        end
      end
      AUTO: begin
        if (key_hit) begin
          nom_state = KEY;
          cand      = key_mot;
        end else if (auto_req) begin
          cand  = auto_mot;
          ack_d = 1'b1;
        end
      end
      HOLDOFF: begin
        if (hold_cnt_q <= HW'(1)) begin
          nom_state = ret_q;
          hold_nom  = '0;
        end else begin
          hold_nom = hold_cnt_q - HW'(1);
        end
      end
      default: begin
        nom_state = IDLE;
        cand      = '0;
      end
    endcase
  end

  wall_predict #(
    .X_MIN (X_MIN),
    .X_MAX (X_MAX),
    .Y_MIN (Y_MIN),
    .Y_MAX (Y_MAX),
    .STEP  (STEP)
  ) u_wall_predict (
    .ball_x   (BallX),
    .ball_y   (BallY),
    .ball_s   (BallS),
    .motion_x (cand.x),
    .motion_y (cand.y),
    .bounce   (wall_hit),
    .refl_x   (refl_x),
    .refl_y   (refl_y)
  );

  // A bounce overrides the requesters' motion in the same frame it is predicted.
  always_comb begin
    state_d    = nom_state;
    ret_d      = ret_q;
    motion_d   = cand;
    hold_cnt_d = hold_nom;
    bounce_d   = 1'b0;
    if ((nom_state == KEY) || (nom_state == AUTO)) begin
      ret_d = nom_state;
    end
    if (wall_hit) begin
      state_d    = HOLDOFF;
      motion_d.x = refl_x;
      motion_d.y = refl_y;
      hold_cnt_d = HOLD_MAX;
      bounce_d   = 1'b1;
    end
    owner_d = (state_d == AUTO) || ((state_d == HOLDOFF) && (ret_d == AUTO));
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      ret_q      <= KEY;
      motion_q   <= '0;
      owner_q    <= 1'b0;
      ack_q      <= 1'b0;
      bounce_q   <= 1'b0;
      idle_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      motion_q   <= motion_d;
      owner_q    <= owner_d;
      ack_q      <= ack_d;
      bounce_q   <= bounce_d;
      idle_cnt_q <= idle_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign Motion_X = motion_q.x;
  assign Motion_Y = motion_q.y;
  assign Owner    = owner_q;
  assign auto_ack = ack_q;
  assign Bounce   = bounce_q;

endmodule
